keypad_scanner: RTL

//   Scans a 4x4 matrix keypad, debounces it and emits one 4-bit key code per

---
 rtl/keypad_scanner.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotating active-low column drive, synchronised
// row sampling, per-scan hit classification and a debounce FSM that emits one pulse per press.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_PRESSED,
    S_RELEASE
  } state_t;

  logic [3:0]       r_row_s1, r_row_s2;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_col;
  logic [3:0]       r_col_out;
  logic [1:0]       r_hits;
  logic [3:0]       r_code;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_cand;
  logic [3:0]       r_key_code;
  logic             r_key_valid;
  logic             r_key_held;

  logic             w_sample;
  logic             w_scan_done;
  logic [2:0]       w_col_hits;
  logic [3:0]       w_col_code;
  logic [2:0]       w_sum;
  logic [1:0]       w_tot;
  logic [3:0]       w_code;
  logic             w_none;
  logic             w_one;
  logic [CNT_W-1:0] w_cnt_inc;

  function automatic logic [3:0] f_key(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'b00_00: k = 4'h1;
      4'b00_01: k = 4'h2;
      4'b00_10: k = 4'h3;
      4'b00_11: k = 4'hA;
      4'b01_00: k = 4'h4;
      4'b01_01: k = 4'h5;
      4'b01_10: k = 4'h6;
      4'b01_11: k = 4'hB;
      4'b10_00: k = 4'h7;
      4'b10_01: k = 4'h8;
      4'b10_10: k = 4'h9;
      4'b10_11: k = 4'hC;
      4'b11_00: k = 4'hE;
      4'b11_01: k = 4'h0;
      4'b11_10: k = 4'hF;
      default:  k = 4'hD;
    endcase
    return k;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row_s1 <= 4'hF;
      r_row_s2 <= 4'hF;
    end else begin
      r_row_s1 <= row_in;
      r_row_s2 <= r_row_s1;
    end
  end

  assign w_sample    = (r_div == DIV_LAST);
  assign w_scan_done = w_sample && (r_col == 2'd3);

  // Column advances on the same edge that samples the rows of the old column.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div     <= '0;
      r_col     <= 2'd0;
      r_col_out <= 4'b1110;
    end else if (w_sample) begin
      r_div     <= '0;
      r_col     <= r_col + 2'd1;
      r_col_out <= {r_col_out[2:0], r_col_out[3]};
    end else begin
      r_div     <= r_div + DIV_W'(1);
    end
  end

  always_comb begin
    w_col_hits = 3'd0;
    w_col_code = 4'h0;
    for (int r = 3; r >= 0; r--) begin
      if (!r_row_s2[r]) begin
        w_col_hits = w_col_hits + 3'd1;
        w_col_code = f_key(2'(r), r_col);
      end
    end
  end

  assign w_sum  = 3'(r_hits) + w_col_hits;
  assign w_tot  = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
  assign w_code = (r_hits != 2'd0) ? r_code : w_col_code;
  assign w_none = (w_tot == 2'd0);
  assign w_one  = (w_tot == 2'd1);

  // Hit count saturates at 2: anything beyond one hit is just MULTI.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hits <= 2'd0;
      r_code <= 4'h0;
    end else if (w_scan_done) begin
      r_hits <= 2'd0;
      r_code <= 4'h0;
    end else if (w_sample) begin
      r_hits <= w_tot;
      if (r_hits == 2'd0 && w_col_hits != 3'd0) r_code <= w_col_code;
    end
  end

  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cand      <= 4'h0;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_scan_done) begin
        case (r_state)
          S_IDLE: begin
            if (w_one) begin
              r_state <= S_DEBOUNCE;
              r_cand  <= w_code;
              r_cnt   <= CNT_W'(1);
            end
          end
          S_DEBOUNCE: begin
            if (w_one && w_code == r_cand) begin
              if (w_cnt_inc == CNT_MAX) begin
                r_state     <= S_PRESSED;
                r_cnt       <= '0;
                r_key_code  <= r_cand;
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else if (w_one) begin
              r_cand <= w_code;
              r_cnt  <= CNT_W'(1);
            end else begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
            end
          end
          S_PRESSED: begin
            if (w_none) begin
              r_state <= S_RELEASE;
              r_cnt   <= CNT_W'(1);
            end
          end
          default: begin
            if (!w_none) begin
              r_state <= S_PRESSED;
              r_cnt   <= '0;
            end else if (w_cnt_inc == CNT_MAX) begin
              r_state    <= S_IDLE;
              r_cnt      <= '0;
              r_key_held <= 1'b0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        endcase
      end
    end
  end

  assign col_out   = r_col_out;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule
